// File: rtl/ppu_pkg.sv
// Shared types and defaults for the PPU framebuffer write path.
package ppu_pkg;
  localparam logic [23:0] WIN_BASE_DEF = 24'hf00000;
  localparam logic [23:0] WIN_LAST_DEF = 24'hf1ffff;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [23:0] addr;
    rgb565_t     data;
  } fb_entry_t;

  typedef enum logic {ST_IDLE, ST_REQ} wr_state_e;

  // Plain truncation of each channel to its 565 width.
  function automatic rgb565_t rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction
endpackage

// File: rtl/ppu_fb_writer_sync_fifo.sv
// Synchronous FIFO with registered level; head is visible combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_PPU,
  input  logic             n_reset_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = ram[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_PPU) begin
    if (do_push) ram[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ppu_fb_writer.sv
// Windowed pixel capture into a FIFO, drained as RGB565 writes to framebuffer memory.
module ppu_fb_writer
  import ppu_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [23:0] WIN_BASE = WIN_BASE_DEF,
  parameter logic [23:0] WIN_LAST = WIN_LAST_DEF,
  localparam int         LW       = $clog2(DEPTH) + 1
) (
  input  logic          clk_PPU,
  input  logic          n_reset_in,
  input  logic          pix_valid,
  input  logic [23:0]   pix_addr,
  input  logic [23:0]   pix_rgb,
  output logic          mem_req,
  output logic [23:0]   mem_addr,
  output logic [15:0]   mem_data,
  input  logic          mem_ack,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  input  logic          clr_ovf
);
  wr_state_e   state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  rgb565_t     mem_data_q, mem_data_d;
  logic        overflow_q, overflow_d;
  logic        in_win, pop, drop, fifo_full, fifo_empty;
  fb_entry_t   head, wentry;

  assign in_win = pix_valid && (pix_addr >= WIN_BASE) && (pix_addr <= WIN_LAST);
  assign wentry = '{addr: pix_addr, data: rgb888_to_565(pix_rgb)};

  sync_fifo #(.WIDTH($bits(fb_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_PPU    (clk_PPU),
    .n_reset_in (n_reset_in),
    .push       (in_win),
    .pop        (pop),
    .wdata      (wentry),
    .rdata      (head),
    .level      (fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // The holding register refills whenever it is free or its write is being acked.
  assign pop  = !fifo_empty && (state_q == ST_IDLE || mem_ack);
  assign drop = in_win && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (pop) begin
      state_d    = ST_REQ;
      mem_req_d  = 1'b1;
      mem_addr_d = head.addr;
      mem_data_d = head.data;
    end else if (state_q == ST_REQ && mem_ack) begin
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
    end
    overflow_d = drop | (overflow_q & ~clr_ovf);
  end

  always_ff @(posedge clk_PPU or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign overflow = overflow_q;
endmodule

// File: doc/ppu_fb_writer.md
PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in entries; power of two, 4..64.
REQ-002 Parameter WIN_BASE, default 24'hf00000, first framebuffer address accepted.
REQ-003 Parameter WIN_LAST, default 24'hf1ffff, last framebuffer address accepted.
REQ-004 clk_PPU  input  1  pixel clock; all state on its rising edge.
REQ-005 n_reset_in  input  1  reset, asynchronous, active-low.
REQ-006 pix_valid  input  1  pixel strobe; one pixel per cycle while high.
REQ-007 pix_addr  input  24  framebuffer pixel address.
REQ-008 pix_rgb  input  24  pixel colour: R[23:16], G[15:8], B[7:0].
REQ-009 mem_req  output  1  write request to framebuffer memory.
REQ-010 mem_addr  output  24  write address, valid while mem_req is high.
REQ-011 mem_data  output  16  RGB565 write data, valid while mem_req is high.
REQ-012 mem_ack  input  1  memory accepted the current write; sampled only while mem_req is high.
REQ-013 fifo_level  output  log2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag: a pixel was dropped because the FIFO was full.
REQ-015 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-016 Colour conversion SHALL be truncation: {R[7:3], G[7:2], B[7:3]}; no rounding or dithering.
REQ-017 Push condition: pix_valid high, WIN_BASE <= pix_addr <= WIN_LAST, and (fifo_level < DEPTH or a pop in the same cycle).
REQ-018 Out-of-window pixels SHALL be discarded silently, with no FIFO or overflow effect.
REQ-019 An in-window pixel arriving when full with no same-cycle pop SHALL be dropped, and overflow SHALL set the next cycle.
REQ-020 If overflow set and clr_ovf coincide, set SHALL win.
REQ-021 FIFO entries SHALL hold {pix_addr, rgb565} (40 bits) in strict arrival order; read and write pointers wrap modulo DEPTH.
REQ-022 Output FSM states: IDLE, REQ.
- IDLE -> REQ when the FIFO is non-empty: head is loaded into mem_addr/mem_data registers and popped, and mem_req rises the next cycle.
- REQ -> REQ on mem_ack with FIFO non-empty: next head is loaded and popped, and mem_req stays high (back-to-back writes, one per cycle).
- REQ -> IDLE on mem_ack with FIFO empty.
- REQ with no mem_ack: mem_req, mem_addr and mem_data SHALL hold unchanged.
REQ-023 Latency: a pixel pushed into an empty FIFO in cycle N with the FSM in IDLE SHALL appear with mem_req high in cycle N+2 (push at N, load at N+1).
REQ-024 fifo_level SHALL be registered; simultaneous push and pop leaves it unchanged.
REQ-025 The output holding register SHALL NOT be counted in fifo_level, so total storage is DEPTH+1 pixels.

Reset
REQ-026 While n_reset_in is low: mem_req=0, mem_addr=0, mem_data=0, fifo_level=0, overflow=0, both pointers=0, FSM=IDLE.
REQ-027 Reset asserted mid-transfer SHALL abandon the outstanding write and discard all FIFO contents; no write is replayed after reset.
REQ-028 Release of n_reset_in SHALL take effect on the first clk_PPU edge after deassertion; the FIFO RAM needs no reset.

Structure
REQ-029 Package ppu_pkg SHALL hold rgb565_t, the fb_entry_t struct {addr, data}, the WIN_BASE/WIN_LAST defaults and the rgb888-to-565 conversion function.
REQ-030 Buffering SHALL be one sub-module, sync_fifo (parameterised width/depth, registered level, full/empty outputs); the FSM and window check live in ppu_fb_writer.

Verification
REQ-031 Single pixel: addr f00000, rgb 0000ff, mem_ack tied high -> mem_req high for exactly one cycle, at N+2, with mem_addr=f00000 and mem_data=001f.
REQ-032 Stall: 20 consecutive in-window pixels, mem_ack low -> DEPTH+1=17 stored, fifo_level=16, overflow set after pixel 18; on releasing ack, 17 writes in order, then mem_req low.
REQ-033 Window: pixels at efffff, f00000, f1ffff, f20000 -> only f00000 and f1ffff are written; overflow stays 0.
REQ-034 Full with simultaneous ack: FIFO full, mem_ack high and pix_valid high in the same cycle -> pixel accepted, fifo_level stays 16, no overflow.
REQ-035 Reset mid-burst: 8 queued, mem_req high, n_reset_in pulsed low -> all outputs 0 immediately; no writes after release until new pixels arrive.
REQ-036 Overflow clear: clr_ovf high in the same cycle as a new drop -> overflow remains 1; clr_ovf alone on a later cycle -> overflow reads 0.
